coin_acceptor: RTL
==================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE, default 4, number of consecutive stable synchronized samples required to qualify coin insertion or removal (legal range 2..15).
REQ-002 Parameter CNT_W, default 8, width of the per-denomination coin counters.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 coin_present  input  1  raw, asynchronous coin-slot sensor; 1 = coin in slot.
REQ-006 coin_type  input  2  raw sensor classification: 01 = half, 10 = one, 00/11 = invalid.
REQ-007 accept_en  input  1  synchronous enable from the vending machine; 0 = reject all coins.
REQ-008 half  output  1  registered single-cycle strobe: one half-unit coin accepted; drives the vending machine half input.
REQ-009 one  output  1  registered single-cycle strobe: one full-unit coin accepted; drives the vending machine one input.
REQ-010 reject  output  1  registered single-cycle strobe: coin routed to return chute.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 cnt_half  output  CNT_W  saturating count of accepted half coins.
REQ-013 cnt_one  output  CNT_W  saturating count of accepted one coins.

Function
REQ-014 coin_present and coin_type shall pass through a 2-flop synchronizer before any use; the FSM sees only synchronized values.
REQ-015 FSM states: IDLE, SETTLE, CLASSIFY, EMIT, CLEAR.
REQ-016 IDLE: on synchronized present=1, go to SETTLE, load debounce count = 1, latch synchronized coin_type.
REQ-017 SETTLE: each cycle with present=1 and type equal to the latched type increments the count; on reaching DEBOUNCE, go to CLASSIFY.
REQ-018 SETTLE: present=0 returns to IDLE with no strobe; a type change reloads count = 1 and relatches the type.
REQ-019 CLASSIFY, one cycle: accept_en=1 with type 01 or 10 goes to EMIT; otherwise assert reject for one cycle and go to CLEAR.
REQ-020 EMIT, one cycle: assert half (type 01) or one (type 10) for exactly one cycle, increment the matching counter, then go to CLEAR.
REQ-021 half, one and reject shall be mutually exclusive, and at most one strobe shall occur per coin insertion.
REQ-022 Strobe timing: with the first rising edge sampling coin_present=1 as edge N and a clean input, the strobe is high for exactly the cycle following edge N+DEBOUNCE+2.
REQ-023 CLEAR: requires DEBOUNCE consecutive synchronized present=0 samples before returning to IDLE; any present=1 sample restarts that count.
REQ-024 CLEAR: a coin held in the slot indefinitely produces no further strobes.
REQ-025 Counters saturate at 2^CNT_W-1 and do not wrap; the half/one strobe still asserts at saturation.
REQ-026 accept_en is sampled only in CLASSIFY; changes in any other state have no effect on the coin in progress.

Reset
REQ-027 While reset=1: FSM = IDLE; half, one, reject, busy = 0; cnt_half, cnt_one = 0; synchronizer and debounce counters cleared.
REQ-028 Reset asserted mid-operation, including during EMIT, aborts the coin with no strobe after reset assertion.
REQ-029 After reset release, a coin already present is detected as a new insertion through the normal SETTLE path.

Verification
REQ-030 DEBOUNCE=4, accept_en=1, coin_present=1 with coin_type=01 held for 20 cycles then 0 -> half=1 for exactly one cycle at edge N+6, cnt_half=1, busy low again 6 cycles after removal.
REQ-031 Same stimulus with coin_type=10 and accept_en=0 -> reject one-cycle pulse, half=one=0, cnt_one unchanged.
REQ-032 coin_present=1 for 3 cycles, then 0 (glitch shorter than DEBOUNCE) -> no strobe, FSM back in IDLE, counters unchanged.
REQ-033 coin_type=11 held stable -> reject only; coin_type toggling 01/10 every 2 cycles -> no strobe while toggling.
REQ-034 260 clean half insertions -> 260 half pulses, cnt_half stops at 255.
REQ-035 reset asserted at edge N+5 of a valid insertion -> no strobe, all outputs 0; after release with coin still present -> exactly one strobe.

Source files
------------

// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronizes and debounces a coin-slot sensor, classifies the coin and emits accept/reject strobes
module coin_acceptor #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coin_present,
    input  logic [1:0]       coin_type,
    input  logic             accept_en,
    output logic             half,
    output logic             one,
    output logic             reject,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_half,
    output logic [CNT_W-1:0] cnt_one
);
    typedef enum logic [2:0] {IDLE, SETTLE, CLASSIFY, EMIT, CLEAR} state_t;

    localparam logic [3:0] D = 4'(DEBOUNCE);

    state_t           r_state;
    logic             r_pres_s1, r_pres_s2;
    logic [1:0]       r_type_s1, r_type_s2;
    logic [1:0]       r_type;
    logic [3:0]       r_cnt;
    logic             r_half, r_one, r_reject;
    logic [CNT_W-1:0] r_cnt_half, r_cnt_one;
    logic             w_valid;

    assign w_valid  = accept_en && (r_type == 2'b01 || r_type == 2'b10);
    assign half     = r_half;
    assign one      = r_one;
    assign reject   = r_reject;
    assign busy     = r_state != IDLE;
    assign cnt_half = r_cnt_half;
    assign cnt_one  = r_cnt_one;

    // two-flop synchronizer for the raw sensor inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pres_s1 <= 1'b0;
            r_pres_s2 <= 1'b0;
            r_type_s1 <= 2'b00;
            r_type_s2 <= 2'b00;
        end else begin
            r_pres_s1 <= coin_present;
            r_pres_s2 <= r_pres_s1;
            r_type_s1 <= coin_type;
            r_type_s2 <= r_type_s1;
        end
    end

    // coin FSM: debounce insertion, classify once, strobe once, debounce removal
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_type     <= 2'b00;
            r_cnt      <= 4'd0;
            r_half     <= 1'b0;
            r_one      <= 1'b0;
            r_reject   <= 1'b0;
            r_cnt_half <= '0;
            r_cnt_one  <= '0;
        end else begin
            r_half   <= 1'b0;
            r_one    <= 1'b0;
            r_reject <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_pres_s2) begin
                        r_state <= SETTLE;
                        r_cnt   <= 4'd1;
                        r_type  <= r_type_s2;
                    end
                end
                SETTLE: begin
                    if (!r_pres_s2) begin
                        r_state <= IDLE;
                    end else if (r_type_s2 != r_type) begin
                        r_cnt  <= 4'd1;
                        r_type <= r_type_s2;
                    end else if (r_cnt + 4'd1 == D) begin
                        r_cnt   <= D;
                        r_state <= CLASSIFY;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                CLASSIFY: begin
                    r_cnt <= 4'd0;
                    if (w_valid) begin
                        r_state <= EMIT;
                        r_half  <= r_type == 2'b01;
                        r_one   <= r_type == 2'b10;
                        if (r_type == 2'b01 && r_cnt_half != '1)
                            r_cnt_half <= r_cnt_half + 1'b1;
                        if (r_type == 2'b10 && r_cnt_one != '1)
                            r_cnt_one <= r_cnt_one + 1'b1;
                    end else begin
                        r_state  <= CLEAR;
                        r_reject <= 1'b1;
                    end
                end
                EMIT: begin
                    r_state <= CLEAR;
                    r_cnt   <= 4'd0;
                end
                CLEAR: begin
                    if (r_pres_s2) begin
                        r_cnt <= 4'd0;
                    end else if (r_cnt + 4'd1 == D) begin
                        r_cnt   <= 4'd0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
